i2c_tx_fifo: RTL and testbench

//  Transmit buffer between the APB bridge and the I2C core. Stores words written by the bridge
//  (WR_ENA/WRITE_DATA_ON_TX). The core pops them through a registered read port. Returns TX_EMPTY
//  (bridge INT_TX source) and full/level/error status. Single clock domain; no bypass path.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_fifo_mem.sv | 52 +++++
 rtl/i2c_tx_fifo.sv | 122 ++++++++++++
 tb/tb_i2c_tx_fifo.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Purpose: shared I2C widths and word type for the TX and RX FIFOs.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

  // Word width carried between the APB bridge and the I2C core.
  localparam int I2C_DWIDTH    = 32;

  // TX FIFO depth is 2**I2C_TX_AWIDTH words.
  localparam int I2C_TX_AWIDTH = 4;

  // TX almost-empty threshold, in words.
  localparam int I2C_TX_AE_LVL = 2;

  typedef logic [I2C_DWIDTH-1:0] i2c_word_t;

endpackage : i2c_pkg

// File: rtl/i2c_fifo_mem.sv
// Purpose: simple dual-port storage array, synchronous write, registered synchronous read.
// Latency: 1 cycle from rd_en to rd_dat; rd_dat holds when rd_en is low.
// Backpressure: none; the caller guarantees addresses and enables are legal.
module i2c_fifo_mem
  import i2c_pkg::*;
#(
  parameter int DWIDTH = I2C_DWIDTH,
  parameter int AWIDTH = I2C_TX_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_dat,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_dat
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_dat_q;
  logic [DWIDTH-1:0] rd_dat_d;

  // Array write; kept reset-free so the array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Next read word: a read on the same address as a write returns the old contents.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = mem_q[rd_addr];
    end
  end

  // Output register, cleared by reset so the core never sees stale data after init.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule : i2c_fifo_mem

// File: rtl/i2c_tx_fifo.sv
// Purpose: TX word buffer from the APB bridge to the I2C core, with level and sticky error status.
// Latency: 1 cycle RD_EN -> TX_DATA/TX_VALID; status flags update the cycle after an accepted op.
// Backpressure: push while full is dropped (TX_OVF), pop while empty is ignored (TX_UDF).
module i2c_tx_fifo
  import i2c_pkg::*;
#(
  parameter int DWIDTH = I2C_DWIDTH,
  parameter int AWIDTH = I2C_TX_AWIDTH,
  parameter int AE_LVL = I2C_TX_AE_LVL
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              WR_ENA,
  input  logic [DWIDTH-1:0] WRITE_DATA_ON_TX,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] TX_DATA,
  output logic              TX_VALID,
  output logic              TX_EMPTY,
  output logic              TX_FULL,
  output logic              TX_AEMPTY,
  output logic [AWIDTH:0]   TX_COUNT,
  output logic              TX_OVF,
  output logic              TX_UDF,
  input  logic              CLR_ERR
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  typedef logic [AWIDTH:0] ptr_t;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t AE_LVL_P  = ptr_t'(AE_LVL);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic valid_q,  valid_d;
  logic ovf_q,    ovf_d;
  logic udf_q,    udf_d;

  logic empty;
  logic full;
  ptr_t count;
  logic pop_ok;
  logic push_ok;
  logic ovf_set;
  logic udf_set;
  logic mem_wr_en;
  logic mem_rd_en;

  // Occupancy status derived purely from the registered pointers.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
            (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
    count = wr_ptr_q - rd_ptr_q;
  end

  // Accept/reject decisions; a pop frees a slot, so push+pop while full both proceed.
  always_comb begin
    pop_ok    = RD_EN & ~empty;
    push_ok   = WR_ENA & (~full | pop_ok);
    ovf_set   = WR_ENA & full & ~pop_ok;
    udf_set   = RD_EN & empty;
    // Reset takes priority over traffic, so nothing may touch the array or read port then.
    mem_wr_en = push_ok & ~PRESET;
    mem_rd_en = pop_ok & ~PRESET;
  end

  // Next-state for pointers, read-valid and sticky flags; a set event beats CLR_ERR.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    valid_d = pop_ok;
    ovf_d   = ovf_set | (ovf_q & ~CLR_ERR);
    udf_d   = udf_set | (udf_q & ~CLR_ERR);
  end

  // Control state registers with synchronous reset; stored words are simply abandoned.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  i2c_fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk     (PCLK),
    .rst     (PRESET),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_q[AWIDTH-1:0]),
    .wr_dat  (WRITE_DATA_ON_TX),
    .rd_en   (mem_rd_en),
    .rd_addr (rd_ptr_q[AWIDTH-1:0]),
    .rd_dat  (TX_DATA)
  );

  assign TX_VALID  = valid_q;
  assign TX_EMPTY  = empty;
  assign TX_FULL   = full;
  assign TX_AEMPTY = (count <= AE_LVL_P);
  assign TX_COUNT  = count;
  assign TX_OVF    = ovf_q;
  assign TX_UDF    = udf_q;

endmodule : i2c_tx_fifo

// File: tb/tb_i2c_tx_fifo.sv
// Purpose: self-checking bench for i2c_tx_fifo using a word scoreboard queue.
// Latency: expects TX_DATA/TX_VALID one cycle after RD_EN, flags one cycle after the op.
// Backpressure: exercises overflow, underflow and simultaneous push+pop at full/empty.
module tb_i2c_tx_fifo;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        WR_ENA = 1'b0;
  logic [31:0] WRITE_DATA_ON_TX = '0;
  logic        RD_EN = 1'b0;
  logic [31:0] TX_DATA;
  logic        TX_VALID;
  logic        TX_EMPTY;
  logic        TX_FULL;
  logic        TX_AEMPTY;
  logic [4:0]  TX_COUNT;
  logic        TX_OVF;
  logic        TX_UDF;
  logic        CLR_ERR = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_w;

  i2c_tx_fifo dut (
    .PCLK             (PCLK),
    .PRESET           (PRESET),
    .WR_ENA           (WR_ENA),
    .WRITE_DATA_ON_TX (WRITE_DATA_ON_TX),
    .RD_EN            (RD_EN),
    .TX_DATA          (TX_DATA),
    .TX_VALID         (TX_VALID),
    .TX_EMPTY         (TX_EMPTY),
    .TX_FULL          (TX_FULL),
    .TX_AEMPTY        (TX_AEMPTY),
    .TX_COUNT         (TX_COUNT),
    .TX_OVF           (TX_OVF),
    .TX_UDF           (TX_UDF),
    .CLR_ERR          (CLR_ERR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Drive one cycle of inputs, clock it, and return #1 after the edge for sampling.
  task automatic cyc(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
    WR_ENA = wr; WRITE_DATA_ON_TX = d; RD_EN = rd; CLR_ERR = clr;
    @(posedge PCLK); #1;
    WR_ENA = 1'b0; RD_EN = 1'b0; CLR_ERR = 1'b0;
  endtask

  // Pop one word, comparing TX_VALID and TX_DATA against the scoreboard head.
  task automatic pop_and_check(input string tag);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (TX_VALID !== 1'b1) begin n_bad++; $display("FAIL %s valid: got %b required 1", tag, TX_VALID); end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL %s scoreboard: got pop required no pop", tag); end
    else begin
      exp_w = sb.pop_front();
      if (TX_DATA !== exp_w) begin n_bad++; $display("FAIL %s data: got %h required %h", tag, TX_DATA, exp_w); end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    PRESET = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    sb.delete();
    n_cmp++; if (TX_EMPTY !== 1'b1) begin n_bad++; $display("FAIL reset empty: got %b required 1", TX_EMPTY); end
    n_cmp++; if (TX_AEMPTY !== 1'b1) begin n_bad++; $display("FAIL reset aempty: got %b required 1", TX_AEMPTY); end
    n_cmp++; if (TX_FULL !== 1'b0) begin n_bad++; $display("FAIL reset full: got %b required 0", TX_FULL); end
    n_cmp++; if (TX_COUNT !== 5'd0) begin n_bad++; $display("FAIL reset count: got %0d required 0", TX_COUNT); end
    n_cmp++; if (TX_VALID !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %b required 0", TX_VALID); end
    n_cmp++; if (TX_DATA !== 32'h0) begin n_bad++; $display("FAIL reset data: got %h required 0", TX_DATA); end
    n_cmp++; if ({TX_OVF, TX_UDF} !== 2'b00) begin n_bad++; $display("FAIL reset errs: got %b required 00", {TX_OVF, TX_UDF}); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0);
      sb.push_back(32'hA5A5_0000 + 32'(i));
      n_cmp++; if (TX_COUNT !== 5'(i)) begin n_bad++; $display("FAIL basic count: got %0d required %0d", TX_COUNT, i); end
      n_cmp++; if (TX_EMPTY !== 1'b0) begin n_bad++; $display("FAIL basic empty: got %b required 0", TX_EMPTY); end
      n_cmp++; if (TX_AEMPTY !== (i <= 2)) begin n_bad++; $display("FAIL basic aempty: got %b required %b", TX_AEMPTY, (i <= 2)); end
    end
    for (int i = 0; i < 3; i++) pop_and_check("basic");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (TX_VALID !== 1'b0) begin n_bad++; $display("FAIL basic idle valid: got %b required 0", TX_VALID); end
    n_cmp++; if (TX_DATA !== 32'hA5A5_0003) begin n_bad++; $display("FAIL basic hold data: got %h required a5a50003", TX_DATA); end
    n_cmp++; if (TX_EMPTY !== 1'b1) begin n_bad++; $display("FAIL basic end empty: got %b required 1", TX_EMPTY); end
  endtask

  task automatic test_full_ovf();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
      sb.push_back(32'h1000_0000 + 32'(i));
    end
    n_cmp++; if (TX_FULL !== 1'b1) begin n_bad++; $display("FAIL full flag: got %b required 1", TX_FULL); end
    n_cmp++; if (TX_COUNT !== 5'd16) begin n_bad++; $display("FAIL full count: got %0d required 16", TX_COUNT); end
    n_cmp++; if (TX_OVF !== 1'b0) begin n_bad++; $display("FAIL full ovf early: got %b required 0", TX_OVF); end
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    n_cmp++; if (TX_OVF !== 1'b1) begin n_bad++; $display("FAIL ovf set: got %b required 1", TX_OVF); end
    n_cmp++; if (TX_COUNT !== 5'd16) begin n_bad++; $display("FAIL ovf count: got %0d required 16", TX_COUNT); end
    for (int i = 0; i < 16; i++) pop_and_check("full drain");
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (TX_OVF !== 1'b0) begin n_bad++; $display("FAIL ovf clear: got %b required 0", TX_OVF); end
    n_cmp++; if (TX_EMPTY !== 1'b1) begin n_bad++; $display("FAIL full drained empty: got %b required 1", TX_EMPTY); end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0);
      sb.push_back(32'h2000_0000 + 32'(i));
    end
    cyc(1'b1, 32'h2FFF_FFFF, 1'b1, 1'b0);
    sb.push_back(32'h2FFF_FFFF);
    exp_w = sb.pop_front();
    n_cmp++; if (TX_COUNT !== 5'd16) begin n_bad++; $display("FAIL fullpp count: got %0d required 16", TX_COUNT); end
    n_cmp++; if (TX_VALID !== 1'b1) begin n_bad++; $display("FAIL fullpp valid: got %b required 1", TX_VALID); end
    n_cmp++; if (TX_DATA !== exp_w) begin n_bad++; $display("FAIL fullpp data: got %h required %h", TX_DATA, exp_w); end
    n_cmp++; if (TX_OVF !== 1'b0) begin n_bad++; $display("FAIL fullpp ovf: got %b required 0", TX_OVF); end
    for (int i = 0; i < 16; i++) pop_and_check("fullpp drain");
    n_cmp++; if (TX_DATA !== 32'h2FFF_FFFF) begin n_bad++; $display("FAIL fullpp last: got %h required 2fffffff", TX_DATA); end
  endtask

  task automatic test_empty_pushpop();
    cyc(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    sb.push_back(32'h0000_1234);
    n_cmp++; if (TX_VALID !== 1'b0) begin n_bad++; $display("FAIL emptypp valid: got %b required 0", TX_VALID); end
    n_cmp++; if (TX_UDF !== 1'b1) begin n_bad++; $display("FAIL emptypp udf: got %b required 1", TX_UDF); end
    n_cmp++; if (TX_COUNT !== 5'd1) begin n_bad++; $display("FAIL emptypp count: got %0d required 1", TX_COUNT); end
    pop_and_check("emptypp");
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (TX_UDF !== 1'b0) begin n_bad++; $display("FAIL udf clear: got %b required 0", TX_UDF); end
    // Underflow event coinciding with CLR_ERR must leave the flag set.
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++; if (TX_UDF !== 1'b1) begin n_bad++; $display("FAIL udf set wins: got %b required 1", TX_UDF); end
    n_cmp++; if (TX_VALID !== 1'b0) begin n_bad++; $display("FAIL udf valid: got %b required 0", TX_VALID); end
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++; if (TX_UDF !== 1'b0) begin n_bad++; $display("FAIL udf clear2: got %b required 0", TX_UDF); end
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    for (int i = 0; i < 40; i++) begin
      w = 32'h3000_0000 ^ ($urandom() & 32'h00FF_FF00) ^ 32'(i);
      if (i < 4) begin
        cyc(1'b1, w, 1'b0, 1'b0);
        sb.push_back(w);
      end else begin
        cyc(1'b1, w, 1'b1, 1'b0);
        exp_w = sb.pop_front();
        sb.push_back(w);
        n_cmp++; if (TX_VALID !== 1'b1 || TX_DATA !== exp_w) begin n_bad++; $display("FAIL wrap data: got %b/%h required 1/%h", TX_VALID, TX_DATA, exp_w); end
      end
    end
    n_cmp++; if (TX_COUNT !== 5'd4) begin n_bad++; $display("FAIL wrap count: got %0d required 4", TX_COUNT); end
    for (int i = 0; i < 4; i++) pop_and_check("wrap drain");
    n_cmp++; if (TX_EMPTY !== 1'b1) begin n_bad++; $display("FAIL wrap empty: got %b required 1", TX_EMPTY); end
  endtask

  task automatic test_reset_traffic();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
    n_cmp++; if (TX_COUNT !== 5'd5) begin n_bad++; $display("FAIL rst traffic pre count: got %0d required 5", TX_COUNT); end
    PRESET = 1'b1;
    cyc(1'b1, 32'h4444_4444, 1'b1, 1'b0);
    PRESET = 1'b0;
    sb.delete();
    n_cmp++; if (TX_EMPTY !== 1'b1) begin n_bad++; $display("FAIL rst traffic empty: got %b required 1", TX_EMPTY); end
    n_cmp++; if (TX_COUNT !== 5'd0) begin n_bad++; $display("FAIL rst traffic count: got %0d required 0", TX_COUNT); end
    n_cmp++; if (TX_VALID !== 1'b0) begin n_bad++; $display("FAIL rst traffic valid: got %b required 0", TX_VALID); end
    n_cmp++; if (TX_DATA !== 32'h0) begin n_bad++; $display("FAIL rst traffic data: got %h required 0", TX_DATA); end
    cyc(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
    sb.push_back(32'h5555_AAAA);
    pop_and_check("post reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_ovf();
    test_full_pushpop();
    test_empty_pushpop();
    test_wrap();
    test_reset_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_i2c_tx_fifo
